// File: rtl/rds_decoder.sv
// rds_decoder: RDS offset-word block sync, good/bad block classification
// and 4-block group assembly from a recovered 1187.5 bit/s bitstream.
module rds_decoder #(
  parameter int c_max_bad_blocks = 8,
  parameter bit c_group_out      = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic [15:0] block_data,
  output logic [2:0]  block_id,
  output logic        block_ok,
  output logic        block_valid,
  output logic [63:0] group_data,
  output logic        group_valid,
  output logic        synced
);

  localparam logic [2:0] ID_A  = 3'd0;
  localparam logic [2:0] ID_B  = 3'd1;
  localparam logic [2:0] ID_C  = 3'd2;
  localparam logic [2:0] ID_CP = 3'd3;
  localparam logic [2:0] ID_D  = 3'd4;

  typedef enum logic [1:0] {
    S_SEARCH,
    S_PRESYNC,
    S_SYNC
  } state_t;

  state_t      r_state;
  logic [24:0] r_sr;
  logic [4:0]  r_fill;
  logic [4:0]  r_bitcnt;
  logic [3:0]  r_badcnt;
  logic [2:0]  r_exp;
  logic [15:0] r_slot_a;
  logic [15:0] r_slot_b;
  logic [15:0] r_slot_c;
  logic        r_have_a;
  logic        r_have_b;
  logic        r_have_c;

  logic [25:0] w_sr;
  logic [15:0] w_data;
  logic [9:0]  w_syn;
  logic [2:0]  w_id;
  logic        w_hit;
  logic        w_ok;
  logic        w_fill_full;
  logic        w_blk_end;
  logic        w_lose;

  function automatic logic [9:0] crc10(input logic [15:0] d);
    logic [9:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--)
      r = {r[8:0], 1'b0} ^ ({10{r[9] ^ d[i]}} & 10'h1B9);
    return r;
  endfunction

  function automatic logic [2:0] succ(input logic [2:0] id);
    logic [2:0] n;
    case (id)
      ID_A:       n = ID_B;
      ID_B:       n = ID_C;
      ID_C, ID_CP: n = ID_D;
      default:    n = ID_A;
    endcase
    return n;
  endfunction

  // Decisions use the word including the bit being shifted in now.
  assign w_sr   = {r_sr, bit_in};
  assign w_data = w_sr[25:10];
  assign w_syn  = w_sr[9:0] ^ crc10(w_data);

  always_comb begin
    w_hit = 1'b1;
    w_id  = ID_A;
    unique case (w_syn)
      10'h0FC: w_id = ID_A;
      10'h198: w_id = ID_B;
      10'h168: w_id = ID_C;
      10'h350: w_id = ID_CP;
      10'h1B4: w_id = ID_D;
      default: w_hit = 1'b0;
    endcase
  end

  assign w_ok = w_hit &&
    ((w_id == r_exp) || (r_exp == ID_C && w_id == ID_CP));
  assign w_fill_full = (r_fill >= 5'd25);
  assign w_blk_end   = (r_bitcnt == 5'd25);
  assign w_lose = !w_ok &&
    (r_badcnt == 4'(c_max_bad_blocks - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_SEARCH;
      r_sr        <= '0;
      r_fill      <= '0;
      r_bitcnt    <= '0;
      r_badcnt    <= '0;
      r_exp       <= ID_A;
      r_slot_a    <= '0;
      r_slot_b    <= '0;
      r_slot_c    <= '0;
      r_have_a    <= 1'b0;
      r_have_b    <= 1'b0;
      r_have_c    <= 1'b0;
      block_data  <= '0;
      block_id    <= '0;
      block_ok    <= 1'b0;
      block_valid <= 1'b0;
      group_data  <= '0;
      group_valid <= 1'b0;
      synced      <= 1'b0;
    end else begin
      block_valid <= 1'b0;
      group_valid <= 1'b0;
      if (bit_valid) begin
        r_sr <= w_sr[24:0];
        if (r_fill != 5'd26) r_fill <= r_fill + 5'd1;
        unique case (r_state)
          S_SEARCH: begin
            if (w_fill_full && w_hit) begin
              r_exp    <= succ(w_id);
              r_bitcnt <= '0;
              r_state  <= S_PRESYNC;
            end
          end
          S_PRESYNC: begin
            if (w_blk_end) begin
              r_bitcnt <= '0;
              if (w_ok) begin
                r_state  <= S_SYNC;
                r_exp    <= succ(r_exp);
                r_badcnt <= '0;
                synced   <= 1'b1;
              end else begin
                r_state <= S_SEARCH;
              end
            end else begin
              r_bitcnt <= r_bitcnt + 5'd1;
            end
          end
          S_SYNC: begin
            if (w_blk_end) begin
              r_bitcnt    <= '0;
              r_exp       <= succ(r_exp);
              block_valid <= 1'b1;
              block_data  <= w_data;
              block_id    <= w_ok ? w_id : r_exp;
              block_ok    <= w_ok;
              if (w_ok) begin
                r_badcnt <= '0;
              end else if (w_lose) begin
                r_badcnt <= '0;
                r_state  <= S_SEARCH;
                r_fill   <= '0;
                synced   <= 1'b0;
              end else begin
                r_badcnt <= r_badcnt + 4'd1;
              end
              // Group slots: C and C' share one slot.
              if (!w_ok) begin
                r_have_a <= 1'b0;
                r_have_b <= 1'b0;
                r_have_c <= 1'b0;
              end else begin
                case (w_id)
                  ID_A: begin
                    r_slot_a <= w_data;
                    r_have_a <= 1'b1;
                    r_have_b <= 1'b0;
                    r_have_c <= 1'b0;
                  end
                  ID_B: begin
                    r_slot_b <= w_data;
                    r_have_b <= 1'b1;
                  end
                  ID_C, ID_CP: begin
                    r_slot_c <= w_data;
                    r_have_c <= 1'b1;
                  end
                  ID_D: begin
                    if (c_group_out && r_have_a &&
                        r_have_b && r_have_c) begin
                      group_valid <= 1'b1;
                      group_data  <= {r_slot_a, r_slot_b,
                                      r_slot_c, w_data};
                    end
                  end
                  default: ;
                endcase
              end
            end else begin
              r_bitcnt <= r_bitcnt + 5'd1;
            end
          end
          default: r_state <= S_SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rds_decoder.sv
// tb_rds_decoder: random-gap RDS bitstream stimulus, polynomial reference
// model and cycle-exact scoreboard for block and group strobes.
module tb_rds_decoder;

  localparam int MAXB = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic [15:0] block_data;
  logic [2:0]  block_id;
  logic        block_ok;
  logic        block_valid;
  logic [63:0] group_data;
  logic        group_valid;
  logic        synced;

  always #5 clk = ~clk;

  rds_decoder #(
    .c_max_bad_blocks(MAXB),
    .c_group_out(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bit_in(bit_in),
    .bit_valid(bit_valid),
    .block_data(block_data),
    .block_id(block_id),
    .block_ok(block_ok),
    .block_valid(block_valid),
    .group_data(group_data),
    .group_valid(group_valid),
    .synced(synced)
  );

  typedef struct {
    int unsigned cyc;
    logic [15:0] data;
    logic [2:0]  id;
    logic        ok;
  } blk_t;

  typedef struct {
    int unsigned cyc;
    logic [63:0] data;
  } grp_t;

  blk_t bq[$];
  grp_t gq[$];

  int unsigned cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int n_b2b_blk = 0;
  int n_b2b_grp = 0;
  bit b2b = 1'b0;

  // Reference model state: stream position within the 4-block group.
  int          m_mode;
  int          m_seen;
  int          m_phase;
  int          m_pos;
  int          m_bad;
  logic [25:0] m_win;
  logic [15:0] m_slot[4];
  bit          m_have[4];
  logic        m_synced = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Syndrome = 26-bit received word modulo g(x).
  function automatic logic [9:0] polymod(input logic [25:0] w);
    logic [25:0] r;
    r = w;
    for (int i = 25; i >= 10; i--)
      if (r[i]) r = r ^ (26'h5B9 << (i - 10));
    return r[9:0];
  endfunction

  function automatic int match(input logic [9:0] s);
    case (s)
      10'h0FC: return 0;
      10'h198: return 1;
      10'h168: return 2;
      10'h350: return 3;
      10'h1B4: return 4;
      default: return -1;
    endcase
  endfunction

  function automatic logic [9:0] off_of(input int id);
    case (id)
      0: return 10'h0FC;
      1: return 10'h198;
      2: return 10'h168;
      3: return 10'h350;
      default: return 10'h1B4;
    endcase
  endfunction

  function automatic int pos_of(input int id);
    return (id == 4) ? 3 : (id == 3) ? 2 : id;
  endfunction

  function automatic int id_of_pos(input int p);
    return (p == 3) ? 4 : p;
  endfunction

  function automatic logic [25:0] enc(input logic [15:0] d, input int id);
    logic [25:0] w;
    w = {d, 10'h000};
    return {d, polymod(w) ^ off_of(id)};
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_seen = 0;
    m_phase = 0;
    m_pos = 0;
    m_bad = 0;
    m_win = '0;
    m_have = '{default: 1'b0};
    m_synced = 1'b0;
  endtask

  task automatic model_bit(input logic b);
    int id;
    bit ok;
    logic [15:0] d;
    blk_t e;
    grp_t g;
    m_win = {m_win[24:0], b};
    if (m_seen < 26) m_seen++;
    id = match(polymod(m_win));
    d = m_win[25:10];
    if (m_mode == 0) begin
      if (m_seen == 26 && id >= 0) begin
        m_pos = (pos_of(id) + 1) % 4;
        m_phase = 0;
        m_mode = 1;
      end
    end else begin
      m_phase++;
      if (m_phase == 26) begin
        m_phase = 0;
        ok = (id >= 0) && (pos_of(id) == m_pos);
        if (m_mode == 1) begin
          if (ok) begin
            m_mode = 2;
            m_synced = 1'b1;
            m_bad = 0;
          end else begin
            m_mode = 0;
          end
        end else begin
          e.cyc = cyc + 1;
          e.data = d;
          e.id = 3'(ok ? id : id_of_pos(m_pos));
          e.ok = ok;
          bq.push_back(e);
          if (!ok) begin
            m_have = '{default: 1'b0};
          end else begin
            if (m_pos == 0) m_have = '{default: 1'b0};
            m_slot[m_pos] = d;
            m_have[m_pos] = 1'b1;
            if (m_pos == 3 && m_have[0] && m_have[1] && m_have[2]) begin
              g.cyc = cyc + 1;
              g.data = {m_slot[0], m_slot[1], m_slot[2], m_slot[3]};
              gq.push_back(g);
            end
          end
          if (ok) begin
            m_bad = 0;
          end else begin
            m_bad++;
            if (m_bad == MAXB) begin
              m_mode = 0;
              m_synced = 1'b0;
              m_seen = 0;
            end
          end
        end
        m_pos = (m_pos + 1) % 4;
      end
    end
  endtask

  // Monitor: cycle-exact scoreboard of both strobe streams.
  always @(posedge clk) begin
    #1;
    while (bq.size() > 0 && bq[0].cyc < cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL block strobe missing: got none, expected id %0d data %0h",
               bq[0].id, bq[0].data);
      void'(bq.pop_front());
    end
    while (gq.size() > 0 && gq[0].cyc < cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL group strobe missing: got none, expected %0h",
               gq[0].data);
      void'(gq.pop_front());
    end
    if (block_valid) begin
      if (bq.size() == 0 || bq[0].cyc != cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected block strobe: got id %0d data %0h, expected none",
                 block_id, block_data);
      end else begin
        blk_t e;
        e = bq.pop_front();
        check("block_data", 64'(block_data), 64'(e.data));
        check("block_id", 64'(block_id), 64'(e.id));
        check("block_ok", 64'(block_ok), 64'(e.ok));
      end
      if (b2b && block_ok) n_b2b_blk++;
    end
    if (group_valid) begin
      if (gq.size() == 0 || gq[0].cyc != cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected group strobe: got %0h, expected none",
                 group_data);
      end else begin
        grp_t g;
        g = gq.pop_front();
        check("group_data", group_data, g.data);
      end
      if (b2b) n_b2b_grp++;
    end
    check("synced", 64'(synced), 64'(m_synced));
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_valid = 1'b0;
    end
  endtask

  task automatic send_bit(input logic b);
    int gap;
    gap = b2b ? 0 : $urandom_range(2, 0);
    repeat (gap) begin
      @(negedge clk);
      bit_valid = 1'b0;
      bit_in = 1'($urandom);
    end
    @(negedge clk);
    bit_valid = 1'b1;
    bit_in = b;
    model_bit(b);
  endtask

  task automatic send_word(input logic [25:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_group(input logic [15:0] b, input int cid,
                            input logic [15:0] c);
    send_word(enc(16'h1234, 0), 26);
    send_word(enc(b, 1), 26);
    send_word(enc(c, cid), 26);
    send_word(enc(16'h4142, 4), 26);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      bit_valid = (i % 2 == 0);
      bit_in = 1'($urandom);
      @(negedge clk);
    end
    check("rst block_data", 64'(block_data), 64'h0);
    check("rst block_id", 64'(block_id), 64'h0);
    check("rst block_ok", 64'(block_ok), 64'h0);
    check("rst block_valid", 64'(block_valid), 64'h0);
    check("rst group_data", group_data, 64'h0);
    check("rst group_valid", 64'(group_valid), 64'h0);
    check("rst synced", 64'(synced), 64'h0);
    bit_valid = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [25:0] w;
    model_reset();
    do_reset();

    // Lock from the middle of block A, clean groups.
    send_word(enc(16'h1234, 0), 10);
    repeat (3) send_group(16'h0408, 2, 16'h2020);
    idle(2);
    check("synced after lock", 64'(synced), 64'h1);

    // C' version groups.
    send_group(16'h0C08, 3, 16'h1234);
    send_group(16'h0C08, 3, 16'h1234);

    // Single bit error in block B.
    send_word(enc(16'h1234, 0), 26);
    w = enc(16'h0408, 1) ^ (26'h1 << $urandom_range(25, 0));
    send_word(w, 26);
    send_word(enc(16'h2020, 2), 26);
    send_word(enc(16'h4142, 4), 26);
    send_group(16'h0408, 2, 16'h2020);
    idle(2);
    check("synced after error", 64'(synced), 64'h1);

    // Loss of sync on consecutive bad blocks, then relock.
    repeat (MAXB) begin
      do w = 26'($urandom);
      while (match(polymod(w)) >= 0);
      send_word(w, 26);
    end
    idle(2);
    check("synced after bad run", 64'(synced), 64'h0);
    repeat (3) send_group(16'h0408, 2, 16'h2020);
    idle(2);
    check("synced after relock", 64'(synced), 64'h1);

    // Continuous bit_valid.
    idle(3);
    b2b = 1'b1;
    repeat (10) send_group(16'h0408, 2, 16'h2020);
    idle(3);
    b2b = 1'b0;
    check("b2b good blocks", 64'(n_b2b_blk), 64'd40);
    check("b2b groups", 64'(n_b2b_grp), 64'd10);

    // Reset in the middle of a block, then lock again.
    send_word(enc(16'h1234, 0), 13);
    idle(2);
    do_reset();
    repeat (2) send_group(16'h0408, 2, 16'h2020);
    idle(5);
    check("pending blocks", 64'(bq.size()), 64'h0);
    check("pending groups", 64'(gq.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rds_decoder.md
# rds_decoder

Receive-side counterpart of the RDS group encoder in the FM transmit chain. It consumes the recovered, differentially decoded 1187.5 bit/s RDS bitstream (one strobe per bit from the 57 kHz demodulator/bit-slicer) and acquires block synchronisation using the RDS offset words. It then outputs checked 16-bit information words and complete 4-block groups for the message store or CPU. It has no error correction: blocks are classified good or bad only.

## Interface
Parameters:
- c_max_bad_blocks, 8: consecutive bad blocks in SYNC that force loss of sync (range 1..15).
- c_group_out, 1: 1 enables group assembly outputs; 0 ties group_valid low.

Ports:
- clk  input  1  system clock (25 MHz in the board design); all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- bit_in  input  1  recovered RDS data bit; sampled only when bit_valid=1.
- bit_valid  input  1  one-cycle strobe per received bit; may be asserted on any cycle, including back-to-back.
- block_data  output  16  information word of the last completed block.
- block_id  output  3  offset of that block: 0=A, 1=B, 2=C, 3=C', 4=D.
- block_ok  output  1  1 = received offset matched the expected offset.
- block_valid  output  1  one-cycle strobe; block_data, block_id and block_ok are valid.
- group_data  output  64  {A, B, C/C', D} information words, A in [63:48].
- group_valid  output  1  one-cycle strobe when a group with all four blocks good completes.
- synced  output  1  1 while in SYNC state.

## Operation
- Shift register sr[25:0]: on bit_valid, sr <= {sr[24:0], bit_in}. Bits are MSB-first: data = sr[25:10], check = sr[9:0].
- Syndrome: rx_offset = check XOR crc10(data). crc10 is the remainder of data·x^10 mod g(x), where g(x) = x^10+x^8+x^7+x^5+x^4+x^3+1 (0x5B9). It is pure combinational logic on sr.
- Offset words: A=0x0FC, B=0x198, C=0x168, C'=0x350, D=0x1B4. Any other rx_offset means no match.
- fill counter: saturates at 26 and counts bits since reset or since entry to SEARCH. No match is accepted before the counter reaches 26.
- States:
  - SEARCH: evaluated on every bit. If rx_offset matches any offset, record exp = successor of the matched block (A→B, B→C, C/C'→D, D→A), clear bitcnt, go to PRESYNC.
  - PRESYNC: bitcnt counts 1..26. When bitcnt reaches 26, test rx_offset against exp; when exp=C, accept either C or C'.
    - Match: go to SYNC, advance exp.
    - No match: return to SEARCH. fill stays at 26, so the search resumes on the next bit.
  - SYNC: every 26th bit completes a block. Emit block_valid with block_id = matched offset (C' reported as 3), or exp when block_ok=0. Advance exp regardless of the outcome.
    - Good block: clear badcnt.
    - Bad block: increment badcnt. When badcnt reaches c_max_bad_blocks, go to SEARCH, clear synced, and reset fill to 0.
- Blocks are emitted only in SYNC. The PRESYNC confirming block is not emitted.
- Group assembly: capture each good block into its group slot.
  - A good A block starts a new group.
  - Any bad block invalidates the pending group.
  - group_valid pulses on a good D when slots A, B and C/C' are all good in the current group. The C and C' forms share a slot.

## Timing
- Reset (reset_n=0 at a clock edge): state SEARCH, sr=0, fill=0, bitcnt=0, badcnt=0. All outputs are 0: block_data, block_id, block_ok, block_valid, group_data, group_valid, synced.
- Latency: block_valid and group_valid assert on the clock edge following the bit_valid cycle that completes the block. Each is high for exactly 1 cycle.
- Data outputs hold their values until the next strobe.
- synced rises on the same edge as the PRESYNC→SYNC transition. It falls on the same edge as the bad block that causes loss of sync; that bad block is still emitted with block_ok=0.
- A bit_valid on every cycle must be handled without loss. Throughput is 1 bit/cycle.
- A reset asserted mid-block discards the partial block and any pending group. No strobe is produced.
- bitcnt wraps 26→1 in SYNC. Block boundaries never slip; bit slips are recovered only through loss of sync.

## Test plan
- Reset behaviour: reset_n low for 3 cycles with bit_valid toggling → all outputs 0 and synced=0; no strobes during or after reset until 26 bits have been received.
- Clean lock: feed correctly encoded groups PI=0x1234, B=0x0408, C=0x2020, D=0x4142, starting mid-block A.
  - synced=1 after the first complete B block following A.
  - block_valid then reports C(2, 0x2020, ok) and D(4, 0x4142, ok).
  - group_valid reports 0x1234_0408_2020_4142 on the second group.
- C' handling: B with version bit set, third block using offset C' and data 0x1234 → block_id=3, block_ok=1, group_valid asserted.
- Single error: flip one bit of block B in SYNC → block_ok=0, block_id=1, no group_valid for that group, synced stays 1, next group valid.
- Loss of sync: with c_max_bad_blocks=8, feed 8 random blocks after lock → 8 strobes with block_ok=0, synced falls on the 8th; relock with clean groups within 2 blocks.
- Back-to-back bits: bit_valid held at 1 continuously for 10 clean groups → 40 block_valid strobes, all ok, 10 group_valid strobes (first group included only if lock is gained on its A).
